// File: rtl/audioport_pkg.sv
// Shared register map, command codes and STATUS layout for the audio port control unit.
package audioport_pkg;

    localparam int unsigned DSP_REGISTERS = 8;

    // Register byte offsets (paddr_in[7:0])
    localparam logic [7:0] ADDR_CMD        = 8'h00;
    localparam logic [7:0] ADDR_STATUS     = 8'h04;
    localparam logic [7:0] ADDR_CFG        = 8'h08;
    localparam logic [7:0] ADDR_LEVEL      = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_THRESH = 8'h10;
    localparam logic [7:0] ADDR_ABUF_DATA  = 8'h14;
    localparam logic [7:0] ADDR_DSP_BASE   = 8'h40;

    // CMD register codes
    localparam logic [31:0] CMD_START  = 32'd1;
    localparam logic [31:0] CMD_STOP   = 32'd2;
    localparam logic [31:0] CMD_CLR    = 32'd3;
    localparam logic [31:0] CMD_CFG    = 32'd4;
    localparam logic [31:0] CMD_LEVEL  = 32'd5;
    localparam logic [31:0] CMD_IRQACK = 32'd6;

    // STATUS bit positions
    localparam int unsigned STATUS_PLAY      = 0;
    localparam int unsigned STATUS_OVF       = 1;
    localparam int unsigned STATUS_UNF       = 2;
    localparam int unsigned STATUS_IRQ       = 3;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CMD,
        REG_STATUS,
        REG_CFG,
        REG_LEVEL,
        REG_THRESH,
        REG_ABUF,
        REG_DSP
    } reg_sel_e;

    // Map a byte offset onto a register; DSP slots must be word aligned and below n_dsp.
    function automatic reg_sel_e decode_reg(input logic [7:0] off, input int unsigned n_dsp);
        logic [7:0] rel;
        reg_sel_e   sel;
        rel = off - ADDR_DSP_BASE;
        sel = REG_NONE;
        case (off)
            ADDR_CMD:        sel = REG_CMD;
            ADDR_STATUS:     sel = REG_STATUS;
            ADDR_CFG:        sel = REG_CFG;
            ADDR_LEVEL:      sel = REG_LEVEL;
            ADDR_IRQ_THRESH: sel = REG_THRESH;
            ADDR_ABUF_DATA:  sel = REG_ABUF;
            default: begin
                if (off >= ADDR_DSP_BASE && rel[1:0] == 2'b00 && 32'(rel[7:2]) < n_dsp) begin
                    sel = REG_DSP;
                end
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_sample_fifo.sv
// Sample FIFO: single-word push, POP_N-word pop, occupancy count 0..DEPTH.
module mc_sample_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned POP_N = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [POP_N-1:0][WIDTH-1:0]  pop_data_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    rd_idx;

    // Present the oldest POP_N words; index 0 is the oldest.
    always_comb begin
        rd_idx     = '0;
        pop_data_o = '0;
        for (int unsigned k = 0; k < POP_N; k++) begin
            rd_idx        = rd_ptr_q + AW'(k);
            pop_data_o[k] = mem_q[rd_idx];
        end
    end

    // Storage, pointers and count; callers only push when not full and pop when count>=POP_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(POP_N);
            end
            count_q <= count_q + CW'(push_i) - (pop_i ? CW'(POP_N) : '0);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mc_control_unit.sv
// APB-controlled audio port: command/config registers, sample FIFO and frame output.
module mc_control_unit
    import audioport_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned N_DSP      = DSP_REGISTERS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        psel_in,
    input  logic                        penable_in,
    input  logic                        pwrite_in,
    input  logic [31:0]                 paddr_in,
    input  logic [31:0]                 pwdata_in,
    output logic [31:0]                 prdata_out,
    output logic                        pready_out,
    output logic                        pslverr_out,
    output logic                        play_out,
    output logic                        clr_out,
    output logic                        cfg_out,
    output logic                        level_out,
    output logic [31:0]                 cfg_reg_out,
    output logic [31:0]                 level_reg_out,
    output logic [N_DSP-1:0][31:0]      dsp_regs_out,
    output logic [CHANNELS-1:0][23:0]   abuf_out,
    output logic                        tick_out,
    output logic                        irq_out,
    input  logic                        req_in
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]                 cfg_q, level_q, thresh_q;
    logic [N_DSP-1:0][31:0]      dsp_q;
    logic [CHANNELS-1:0][23:0]   abuf_q;
    logic                        play_q, ovf_q, unf_q, irq_q, tick_q;
    logic                        clr_pulse_q, cfg_pulse_q, level_pulse_q;

    reg_sel_e                    reg_sel;
    logic [7:0]                  dsp_rel;
    logic [5:0]                  dsp_idx;
    logic                        access, rd_ok, wr_ok, we;
    logic                        fifo_full, push, ovf_set;
    logic                        cmd_we, c_start, c_stop, c_clr, c_cfg, c_level, c_ack;
    logic                        req_act, pop, underrun, irq_set;
    logic [CW-1:0]               count;
    logic [31:0]                 count_after;
    logic [31:0]                 status, rdata;
    logic [CHANNELS-1:0][23:0]   fifo_frame;
    logic [23:0]                 unused_paddr;

    assign unused_paddr = paddr_in[31:8];

    // APB decode, error detection, command strobes and read mux.
    always_comb begin
        reg_sel   = decode_reg(paddr_in[7:0], N_DSP);
        dsp_rel   = paddr_in[7:0] - ADDR_DSP_BASE;
        dsp_idx   = dsp_rel[7:2];
        access    = psel_in & penable_in & rst_n;
        fifo_full = (count == CW'(FIFO_DEPTH));
        rd_ok     = 1'b0;
        wr_ok     = 1'b0;
        case (reg_sel)
            REG_CMD:    wr_ok = 1'b1;
            REG_STATUS: rd_ok = 1'b1;
            REG_CFG, REG_LEVEL, REG_THRESH, REG_DSP: begin
                rd_ok = 1'b1;
                wr_ok = 1'b1;
            end
            REG_ABUF:   wr_ok = 1'b1;
            default: begin
                rd_ok = 1'b0;
                wr_ok = 1'b0;
            end
        endcase

        pslverr_out = access & ((pwrite_in & (~wr_ok | ((reg_sel == REG_ABUF) & fifo_full)))
                              | (~pwrite_in & ~rd_ok));
        we      = access & pwrite_in & wr_ok;
        push    = we & (reg_sel == REG_ABUF) & ~fifo_full;
        ovf_set = we & (reg_sel == REG_ABUF) & fifo_full;

        cmd_we  = we & (reg_sel == REG_CMD);
        c_start = cmd_we & (pwdata_in == CMD_START);
        c_stop  = cmd_we & (pwdata_in == CMD_STOP);
        c_clr   = cmd_we & (pwdata_in == CMD_CLR);
        c_cfg   = cmd_we & (pwdata_in == CMD_CFG);
        c_level = cmd_we & (pwdata_in == CMD_LEVEL);
        c_ack   = cmd_we & (pwdata_in == CMD_IRQACK);

        status                               = '0;
        status[STATUS_PLAY]                  = play_q;
        status[STATUS_OVF]                   = ovf_q;
        status[STATUS_UNF]                   = unf_q;
        status[STATUS_IRQ]                   = irq_q;
        status[STATUS_COUNT_LSB +: 8]        = 8'(count);

        rdata = '0;
        case (reg_sel)
            REG_STATUS: rdata = status;
            REG_CFG:    rdata = cfg_q;
            REG_LEVEL:  rdata = level_q;
            REG_THRESH: rdata = thresh_q;
            REG_DSP: begin
                for (int unsigned i = 0; i < N_DSP; i++) begin
                    if (dsp_idx == 6'(i)) rdata = dsp_q[i];
                end
            end
            default:    rdata = '0;
        endcase
        prdata_out = (access & ~pwrite_in & rd_ok) ? rdata : '0;
    end

    // Frame request handling; CLR in the same cycle suppresses the pop and the tick.
    always_comb begin
        req_act     = play_q & req_in & ~c_clr;
        pop         = req_act & (count >= CW'(CHANNELS));
        underrun    = req_act & ~pop;
        count_after = 32'(count) + 32'(push) - (pop ? 32'(CHANNELS) : 32'd0);
        irq_set     = pop & (32'(count) > thresh_q) & (count_after <= thresh_q);
    end

    mc_sample_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH),
        .POP_N (CHANNELS)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (c_clr),
        .push_i      (push),
        .push_data_i (pwdata_in[23:0]),
        .pop_i       (pop),
        .pop_data_o  (fifo_frame),
        .count_o     (count)
    );

    // Register file, play state, status flags, output frame and one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q         <= '0;
            level_q       <= '0;
            thresh_q      <= '0;
            dsp_q         <= '0;
            abuf_q        <= '0;
            play_q        <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            irq_q         <= 1'b0;
            tick_q        <= 1'b0;
            clr_pulse_q   <= 1'b0;
            cfg_pulse_q   <= 1'b0;
            level_pulse_q <= 1'b0;
        end else begin
            if (we && reg_sel == REG_CFG)    cfg_q    <= pwdata_in;
            if (we && reg_sel == REG_LEVEL)  level_q  <= pwdata_in;
            if (we && reg_sel == REG_THRESH) thresh_q <= pwdata_in;
            for (int unsigned i = 0; i < N_DSP; i++) begin
                if (we && reg_sel == REG_DSP && dsp_idx == 6'(i)) dsp_q[i] <= pwdata_in;
            end

            if (c_start)     play_q <= 1'b1;
            else if (c_stop) play_q <= 1'b0;

            clr_pulse_q   <= c_clr;
            cfg_pulse_q   <= c_cfg;
            level_pulse_q <= c_level;
            tick_q        <= req_act;

            if (c_clr) begin
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
                irq_q  <= 1'b0;
                abuf_q <= '0;
            end else begin
                if (ovf_set)  ovf_q <= 1'b1;
                if (underrun) unf_q <= 1'b1;
                if (c_stop || c_ack) irq_q <= 1'b0;
                else if (irq_set)    irq_q <= 1'b1;
                if (pop)           abuf_q <= fifo_frame;
                else if (underrun) abuf_q <= '0;
            end
        end
    end

    assign pready_out    = 1'b1;
    assign play_out      = play_q;
    assign clr_out       = clr_pulse_q;
    assign cfg_out       = cfg_pulse_q;
    assign level_out     = level_pulse_q;
    assign cfg_reg_out   = cfg_q;
    assign level_reg_out = level_q;
    assign dsp_regs_out  = dsp_q;
    assign abuf_out      = abuf_q;
    assign tick_out      = tick_q;
    assign irq_out       = irq_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: directed scenarios then randomized APB/request traffic.
module tb_mc_control_unit;

    localparam int NCH = 4;
    localparam int DEP = 16;
    localparam int NDSP = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  psel_in, penable_in, pwrite_in, req_in;
    logic [31:0]           paddr_in, pwdata_in, prdata_out;
    logic                  pready_out, pslverr_out;
    logic                  play_out, clr_out, cfg_out, level_out;
    logic [31:0]           cfg_reg_out, level_reg_out;
    logic [NDSP-1:0][31:0] dsp_regs_out;
    logic [NCH-1:0][23:0]  abuf_out;
    logic                  tick_out, irq_out;

    mc_control_unit #(.CHANNELS(NCH), .FIFO_DEPTH(DEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psel_in       (psel_in),
        .penable_in    (penable_in),
        .pwrite_in     (pwrite_in),
        .paddr_in      (paddr_in),
        .pwdata_in     (pwdata_in),
        .prdata_out    (prdata_out),
        .pready_out    (pready_out),
        .pslverr_out   (pslverr_out),
        .play_out      (play_out),
        .clr_out       (clr_out),
        .cfg_out       (cfg_out),
        .level_out     (level_out),
        .cfg_reg_out   (cfg_reg_out),
        .level_reg_out (level_reg_out),
        .dsp_regs_out  (dsp_regs_out),
        .abuf_out      (abuf_out),
        .tick_out      (tick_out),
        .irq_out       (irq_out),
        .req_in        (req_in)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned  mq[$];
    logic [95:0]  q_frm[$];
    logic [32:0]  q_apb[$];
    bit           m_play, m_ovf, m_unf, m_irq, m_tick, m_clrp, m_cfgp, m_levp;
    logic [31:0]  m_cfg, m_level, m_thresh;
    logic [31:0]  m_dsp[NDSP];
    logic [95:0]  m_abuf;

    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] dsp_flat();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < NDSP; i++) r[i*32 +: 32] = m_dsp[i];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        q_frm.delete();
        q_apb.delete();
        {m_play, m_ovf, m_unf, m_irq, m_tick, m_clrp, m_cfgp, m_levp} = '0;
        m_cfg = '0; m_level = '0; m_thresh = '0; m_abuf = '0;
        for (int i = 0; i < NDSP; i++) m_dsp[i] = '0;
    endtask

    // One clock cycle: drive inputs, predict responses, advance the model after the edge.
    task automatic cycle(input bit sel, input bit en, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit req,
                         output logic [31:0] rd_cap, output logic err_cap);
        bit acc, is_dsp, er, do_push, popped, req_act;
        bit c_start, c_stop, c_clr, c_cfg, c_lev, c_ack;
        int o, didx;
        int unsigned pre, post;
        logic [31:0] rd;
        logic [95:0] frame;
        bit n_play, n_ovf, n_unf, n_irq, n_tick;
        logic [31:0] n_cfg, n_level, n_thresh;
        logic [31:0] n_dsp[NDSP];
        logic [95:0] n_abuf;

        psel_in = sel; penable_in = en; pwrite_in = wr;
        paddr_in = addr; pwdata_in = data; req_in = req;

        acc = sel && en;
        o = int'(addr[7:0]);
        is_dsp = (o >= 64) && (o % 4 == 0) && ((o - 64) / 4 < NDSP);
        didx = is_dsp ? (o - 64) / 4 : 0;
        er = 0; rd = 0; do_push = 0; popped = 0;
        {c_start, c_stop, c_clr, c_cfg, c_lev, c_ack} = '0;
        n_play = m_play; n_ovf = m_ovf; n_unf = m_unf; n_irq = m_irq;
        n_cfg = m_cfg; n_level = m_level; n_thresh = m_thresh; n_abuf = m_abuf;
        for (int i = 0; i < NDSP; i++) n_dsp[i] = m_dsp[i];

        if (acc) begin
            if (wr) begin
                if (o == 'h00) begin
                    c_start = (data == 1); c_stop = (data == 2); c_clr = (data == 3);
                    c_cfg = (data == 4);   c_lev = (data == 5);  c_ack = (data == 6);
                end else if (o == 'h08) n_cfg = data;
                else if (o == 'h0C) n_level = data;
                else if (o == 'h10) n_thresh = data;
                else if (o == 'h14) begin
                    if (mq.size() == DEP) begin er = 1; n_ovf = 1; end
                    else do_push = 1;
                end else if (is_dsp) n_dsp[didx] = data;
                else er = 1;
            end else begin
                if (o == 'h04)
                    rd = 32'(mq.size() * 256 + m_irq * 8 + m_unf * 4 + m_ovf * 2 + int'(m_play));
                else if (o == 'h08) rd = m_cfg;
                else if (o == 'h0C) rd = m_level;
                else if (o == 'h10) rd = m_thresh;
                else if (is_dsp) rd = m_dsp[didx];
                else er = 1;
            end
            q_apb.push_back({rd, er});
        end

        if (c_start) n_play = 1;
        if (c_stop) n_play = 0;

        req_act = m_play && req && !c_clr;
        pre = mq.size();
        n_tick = req_act;
        if (req_act) begin
            frame = '0;
            if (pre >= NCH) begin
                for (int ch = 0; ch < NCH; ch++) frame[ch*24 +: 24] = 24'(mq.pop_front());
                popped = 1;
            end else begin
                n_unf = 1;
            end
            q_frm.push_back(frame);
            n_abuf = frame;
        end
        if (do_push && !c_clr) mq.push_back(int'(data[23:0]));
        post = mq.size();
        if (popped && 32'(pre) > m_thresh && 32'(post) <= m_thresh) n_irq = 1;
        if (c_stop || c_ack) n_irq = 0;
        if (c_clr) begin
            mq.delete();
            n_abuf = '0; n_ovf = 0; n_unf = 0; n_irq = 0;
        end

        #2;
        rd_cap = prdata_out;
        err_cap = pslverr_out;
        @(posedge clk);
        #1;
        m_play = n_play; m_ovf = n_ovf; m_unf = n_unf; m_irq = n_irq; m_tick = n_tick;
        m_cfg = n_cfg; m_level = n_level; m_thresh = n_thresh; m_abuf = n_abuf;
        for (int i = 0; i < NDSP; i++) m_dsp[i] = n_dsp[i];
        m_clrp = c_clr; m_cfgp = c_cfg; m_levp = c_lev;
    endtask

    task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit req, output logic [31:0] rd, output logic er);
        logic [31:0] d0;
        logic e0;
        cycle(1, 0, wr, addr, data, 0, d0, e0);
        cycle(1, 1, wr, addr, data, req, rd, er);
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d; logic e;
        apb(1, addr, data, 0, d, e);
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] d);
        logic e;
        apb(0, addr, 32'h0, 0, d, e);
    endtask

    task automatic idle(input bit req);
        logic [31:0] d; logic e;
        cycle(0, 0, 0, 32'h0, 32'h0, req, d, e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_prdata"}, prdata_out, 0);
        chk({tag, "_pslverr"}, pslverr_out, 0);
        chk({tag, "_pready"}, pready_out, 1);
        chk({tag, "_flags"}, {play_out, clr_out, cfg_out, level_out, tick_out, irq_out}, 0);
        chk({tag, "_regs"}, {cfg_reg_out, level_reg_out}, 0);
        chk({tag, "_dsp"}, dsp_regs_out, 0);
        chk({tag, "_abuf"}, abuf_out, 0);
    endtask

    // Monitor: pops expected APB responses and frames, compares steady outputs to the model.
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (psel_in && penable_in) begin
                if (q_apb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL apb_unexpected: got access expected none");
                end else begin
                    logic [32:0] e;
                    e = q_apb.pop_front();
                    chk("apb_prdata", prdata_out, e[32:1]);
                    chk("apb_pslverr", pslverr_out, e[0]);
                end
            end else begin
                chk("idle_prdata", prdata_out, 0);
                chk("idle_pslverr", pslverr_out, 0);
            end
            if (tick_out) begin
                if (q_frm.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL frame_unexpected: got tick expected none");
                end else begin
                    chk("frame", abuf_out, q_frm.pop_front());
                end
            end
            chk("tick", tick_out, m_tick);
            chk("abuf", abuf_out, m_abuf);
            chk("play", play_out, m_play);
            chk("irq", irq_out, m_irq);
            chk("pulses", {clr_out, cfg_out, level_out}, {m_clrp, m_cfgp, m_levp});
            chk("cfg_level", {cfg_reg_out, level_reg_out}, {m_cfg, m_level});
            chk("dsp", dsp_regs_out, dsp_flat());
            chk("pready", pready_out, 1);
        end
    end

    initial begin
        logic [31:0] v;
        logic        e;
        int          r, k;
        logic [31:0] a, d;
        bit          rq;

        rst_n = 0;
        psel_in = 0; penable_in = 0; pwrite_in = 0; req_in = 0;
        paddr_in = '0; pwdata_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;
        mon_en = 1;

        // Basic register access and pulse
        rd32(32'h04, v);
        chk("s1_status", v, 0);
        wr32(32'h08, 32'hABCD);
        chk("s1_cfg_reg", cfg_reg_out, 32'hABCD);
        wr32(32'h00, 32'd4);
        chk("s1_cfg_pulse_hi", cfg_out, 1);
        idle(0);
        chk("s1_cfg_pulse_lo", cfg_out, 0);

        // First frame
        for (int i = 1; i <= 8; i++) wr32(32'h14, 32'(i));
        wr32(32'h00, 32'd1);
        idle(1);
        chk("s2_frame", abuf_out, {24'd4, 24'd3, 24'd2, 24'd1});
        chk("s2_tick", tick_out, 1);
        rd32(32'h04, v);
        chk("s2_status", v, 32'h0000_0401);
        wr32(32'h00, 32'd3);
        chk("s2_clr_pulse", clr_out, 1);
        wr32(32'h00, 32'd2);

        // Overflow
        for (int i = 0; i < 16; i++) wr32(32'h14, 32'h100 + 32'(i));
        apb(1, 32'h14, 32'h1FF, 0, v, e);
        chk("s3_ovf_err", e, 1);
        rd32(32'h04, v);
        chk("s3_status", v, 32'h0000_1002);

        // Interrupt threshold
        wr32(32'h00, 32'd3);
        wr32(32'h10, 32'd4);
        for (int i = 0; i < 8; i++) wr32(32'h14, 32'h200 + 32'(i));
        wr32(32'h00, 32'd1);
        idle(1);
        chk("s4_irq_set", irq_out, 1);
        idle(1);
        chk("s4_irq_hold", irq_out, 1);
        wr32(32'h00, 32'd6);
        chk("s4_irq_ack", irq_out, 0);

        // Underrun
        wr32(32'h00, 32'd3);
        for (int i = 0; i < 3; i++) wr32(32'h14, 32'h300 + 32'(i));
        idle(1);
        chk("s5_abuf_zero", abuf_out, 0);
        chk("s5_tick", tick_out, 1);
        rd32(32'h04, v);
        chk("s5_status", v, 32'h0000_0305);

        // Simultaneous push and pop, then reset mid-play
        wr32(32'h00, 32'd3);
        for (int i = 0; i < 8; i++) wr32(32'h14, 32'h400 + 32'(i));
        apb(1, 32'h14, 32'h499, 1, v, e);
        rd32(32'h04, v);
        chk("s6_status", v, 32'h0000_0501);
        idle(0);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Randomized traffic
        wr32(32'h00, 32'd1);
        for (int n = 0; n < 700; n++) begin
            r  = int'($urandom_range(0, 99));
            rq = ($urandom_range(0, 99) < 10);
            a  = $urandom() & 32'hFFFF_FF00;
            if (r < 40) begin
                apb(1, a | 32'h14, $urandom(), rq, v, e);
            end else if (r < 55) begin
                k = int'($urandom_range(0, 99));
                if (k < 35) d = 1;
                else if (k < 43) d = 2;
                else if (k < 48) d = 3;
                else if (k < 58) d = 4;
                else if (k < 68) d = 5;
                else if (k < 80) d = 6;
                else if (k < 90) d = $urandom_range(0, 15);
                else d = $urandom();
                apb(1, a, d, rq, v, e);
            end else if (r < 65) begin
                apb(0, a | 32'h04, $urandom(), rq, v, e);
            end else if (r < 75) begin
                k = int'($urandom_range(0, 2));
                d = (k == 2) ? 32'($urandom_range(0, 16)) : $urandom();
                apb($urandom_range(0, 1) == 1, a | 32'(8 + 4 * k), d, rq, v, e);
            end else if (r < 85) begin
                k = int'($urandom_range(0, 9));
                apb($urandom_range(0, 1) == 1, a | 32'(64 + 4 * k), $urandom(), rq, v, e);
            end else if (r < 90) begin
                apb($urandom_range(0, 1) == 1, a | 32'($urandom_range(0, 255)), $urandom(), rq, v, e);
            end else begin
                idle(rq);
            end
        end
        idle(0);
        idle(0);

        chk("frames_drained", 32'(q_frm.size()), 0);
        chk("apb_drained", 32'(q_apb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
